// File: rtl/error_response_decoder_pkg.sv
// rtl/error_response_decoder_pkg.sv - shared defines, types and helpers for the error response decoder
//
// Purpose: protocol constants (version, ERROR message type, header geometry),
//   error codes shared with the responder-side builder, FSM state encodings,
//   the result record and the helper that folds a decode into that record.
// Ports: none (package).
// Configuration macro used by the decoder: ERR_RX_TIMEOUT_EN.

`ifndef ERROR_RESPONSE_DECODER_DEFINES
`define ERROR_RESPONSE_DECODER_DEFINES
`define PROTOCOL_VERSION        8'h01
`define ERROR_RESP_CMD          8'h7F
`define SIZE_OF_HEADER_VARS     8
`define SIZE_OF_HEADER_IN_BYTES 4

`define ERR_CODE_INVALID_REQ    8'h01
`define ERR_CODE_UNSUP_PROT     8'h02
`define ERR_CODE_BUSY           8'h03
`define ERR_CODE_UNSPEC         8'h04

`define ERD_ST_IDLE             2'd0
`define ERD_ST_HDR              2'd1
`define ERD_ST_TAIL             2'd2
`define ERD_ST_DONE             2'd3
`endif

package error_response_decoder_pkg;

  localparam int HDR_W = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES;

  // Bit positions inside the one-hot error flag vector.
  localparam int FLAG_INV    = 0;
  localparam int FLAG_UNSUP  = 1;
  localparam int FLAG_BUSY   = 2;
  localparam int FLAG_UNSPEC = 3;

  typedef enum logic [1:0] {
    ST_IDLE = `ERD_ST_IDLE,
    ST_HDR  = `ERD_ST_HDR,
    ST_TAIL = `ERD_ST_TAIL,
    ST_DONE = `ERD_ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] flags;
    logic [7:0] param2;
    logic       not_error;
    logic       bad;
  } result_t;

  // Bad wins over everything; otherwise an ERROR carries its flag and Param2,
  // anything else is simply reported as a non-error response.
  function automatic result_t make_result(input logic       bad,
                                          input logic       is_err,
                                          input logic [3:0] flags,
                                          input logic [7:0] param2);
    result_t r;
    r = '0;
    if (bad) begin
      r.bad = 1'b1;
    end else if (is_err) begin
      r.flags  = flags;
      r.param2 = param2;
    end else begin
      r.not_error = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/error_response_decoder_if.sv
// rtl/error_response_decoder_if.sv - receive byte stream bundle from the link layer
//
// Purpose: groups the byte stream handed to the decoder.
// Signals: byte_in[7:0] received byte, byte_valid byte qualifier,
//   SOM first byte of message, EOM last byte of message (both sampled only with byte_valid).
// Modports: master (link layer, drives), slave (decoder, receives).

interface error_response_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       SOM;
  logic       EOM;

  modport master (output byte_in, output byte_valid, output SOM, output EOM);
  modport slave  (input  byte_in, input  byte_valid, input  SOM, input  EOM);
endinterface

// File: rtl/error_response_decoder_error_code_map.sv
// rtl/error_response_decoder_error_code_map.sv - Param1 error code to one-hot error flags
//
// Purpose: combinational mapping shared by decoder and builder sides.
// Ports: code_i[7:0] Param1 of an ERROR response,
//   flags_o[3:0] one-hot {unspecified, busy, unsupported protocol, invalid request}.

module error_code_map
  import error_response_decoder_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [3:0] flags_o
);

  always_comb begin
    flags_o = 4'b0000;
    case (code_i)
      `ERR_CODE_INVALID_REQ: flags_o[FLAG_INV]    = 1'b1;
      `ERR_CODE_UNSUP_PROT:  flags_o[FLAG_UNSUP]  = 1'b1;
      `ERR_CODE_BUSY:        flags_o[FLAG_BUSY]   = 1'b1;
      `ERR_CODE_UNSPEC:      flags_o[FLAG_UNSPEC] = 1'b1;
      // Unknown codes are reported as unspecified so exactly one flag is set.
      default:               flags_o[FLAG_UNSPEC] = 1'b1;
    endcase
  end

endmodule

// File: rtl/error_response_decoder.sv
// rtl/error_response_decoder.sv - initiator-side authentication response header decoder
//
// Purpose: assembles the 4-byte header {version, type, Param1, Param2}, validates
//   framing/length/version and decodes ERROR responses into one-hot flags.
// Ports: clk, reset_L (sync, active low), Enable, rx (byte stream, slave modport);
//   Error_Invalid_Request / Error_Unsupported_Protocol / Error_Busy / Error_Unspecified,
//   Error_Param2[7:0], Not_Error_MSG, Bad_MSG, header[HDR_W-1:0] (byte 0 in MSBs),
//   Decode_done (one-cycle pulse), busy (reception in progress).
// Configuration: define ERR_RX_TIMEOUT_EN to abort a stalled message after
//   RX_TIMEOUT_CYCLES cycles without a byte.

module error_response_decoder
  import error_response_decoder_pkg::*;
#(
  parameter int MAX_MSG_BYTES     = 8,
  parameter int RX_TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    Enable,
  error_response_decoder_if.slave rx,
  output logic                    Error_Invalid_Request,
  output logic                    Error_Unsupported_Protocol,
  output logic                    Error_Busy,
  output logic                    Error_Unspecified,
  output logic [7:0]              Error_Param2,
  output logic                    Not_Error_MSG,
  output logic                    Bad_MSG,
  output logic [HDR_W-1:0]        header,
  output logic                    Decode_done,
  output logic                    busy
);

  // Counter saturates one past the limit so long messages never wrap back to legal.
  localparam int            CW      = $clog2(MAX_MSG_BYTES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_MSG_BYTES);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_MSG_BYTES + 1);
  localparam logic [CW-1:0] CNT_HDR_LAST = CW'(3);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic             bad_q;
  logic [HDR_W-1:0] hdr_q;
  logic [HDR_W-1:0] hdr_next;
  logic [HDR_W-1:0] hdr_cand;
  result_t          res_q;
  result_t          res_fin;
  logic             done_q;

  logic             fin;
  logic             fin_force_bad;
  logic             ver_ok;
  logic             is_err;
  logic             tail_is_err;
  logic             tail_bad;
  logic             tmo_hit;
  logic [3:0]       code_flags;

  assign busy    = (state_q == ST_HDR) || (state_q == ST_TAIL);
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // Header with the current byte dropped into the slot selected by the byte count.
  always_comb begin
    hdr_next = hdr_q;
    case (cnt_q[1:0])
      2'd1:    hdr_next[HDR_W-9  -: 8] = rx.byte_in;
      2'd2:    hdr_next[HDR_W-17 -: 8] = rx.byte_in;
      2'd3:    hdr_next[HDR_W-25 -: 8] = rx.byte_in;
      default: hdr_next = hdr_q;
    endcase
  end

  // An ERROR response carries no payload, so any trailing byte is a violation.
  assign tail_is_err = (hdr_q[HDR_W-9 -: 8] == `ERROR_RESP_CMD);
  assign tail_bad    = bad_q || tail_is_err || (cnt_inc > CNT_MAX);

`ifdef ERR_RX_TIMEOUT_EN
  localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (!reset_L || !Enable || rx.byte_valid || !busy) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = busy && !rx.byte_valid && (tmo_q == TW'(RX_TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^RX_TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Detect the cycle that ends a message and whether framing alone already makes it bad.
  always_comb begin
    fin           = 1'b0;
    fin_force_bad = 1'b0;
    hdr_cand      = hdr_q;
    if (Enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx.byte_valid && rx.SOM && rx.EOM) begin
            fin           = 1'b1;
            fin_force_bad = 1'b1;
          end
        end
        ST_HDR: begin
          if (rx.byte_valid) begin
            if (rx.SOM) begin
              fin           = 1'b1;
              fin_force_bad = 1'b1;
            end else begin
              hdr_cand = hdr_next;
              if (rx.EOM) begin
                fin           = 1'b1;
                fin_force_bad = (cnt_q != CNT_HDR_LAST);
              end
            end
          end else if (tmo_hit) begin
            fin           = 1'b1;
            fin_force_bad = 1'b1;
          end
        end
        ST_TAIL: begin
          if (rx.byte_valid) begin
            if (rx.SOM) begin
              fin           = 1'b1;
              fin_force_bad = 1'b1;
            end else if (rx.EOM) begin
              fin           = 1'b1;
              fin_force_bad = tail_bad;
            end
          end else if (tmo_hit) begin
            fin           = 1'b1;
            fin_force_bad = 1'b1;
          end
        end
        default: begin
          fin = 1'b0;
        end
      endcase
    end
  end

  assign ver_ok = (hdr_cand[HDR_W-1 -: 8] == `PROTOCOL_VERSION);
  assign is_err = (hdr_cand[HDR_W-9 -: 8] == `ERROR_RESP_CMD);

  error_code_map u_code_map (
    .code_i  (hdr_cand[HDR_W-17 -: 8]),
    .flags_o (code_flags)
  );

  assign res_fin = make_result(fin_force_bad || !ver_ok, is_err, code_flags,
                               hdr_cand[HDR_W-25 -: 8]);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      hdr_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!Enable) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (rx.byte_valid && rx.SOM) begin
              hdr_q   <= {rx.byte_in, {(HDR_W-8){1'b0}}};
              cnt_q   <= CW'(1);
              bad_q   <= 1'b0;
              res_q   <= '0;
              state_q <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (rx.byte_valid && !rx.SOM) begin
              hdr_q <= hdr_next;
              cnt_q <= cnt_inc;
              if (cnt_q == CNT_HDR_LAST) begin
                state_q <= ST_TAIL;
              end
            end
          end
          ST_TAIL: begin
            if (rx.byte_valid && !rx.SOM) begin
              cnt_q <= cnt_inc;
              bad_q <= tail_bad;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
        // Ending a message overrides the per-state moves above.
        if (fin) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          res_q   <= res_fin;
        end
      end
    end
  end

  assign Error_Invalid_Request      = res_q.flags[FLAG_INV];
  assign Error_Unsupported_Protocol = res_q.flags[FLAG_UNSUP];
  assign Error_Busy                 = res_q.flags[FLAG_BUSY];
  assign Error_Unspecified          = res_q.flags[FLAG_UNSPEC];
  assign Error_Param2               = res_q.param2;
  assign Not_Error_MSG              = res_q.not_error;
  assign Bad_MSG                    = res_q.bad;
  assign header                     = hdr_q;
  assign Decode_done                = done_q;

endmodule

// File: tb/tb_error_response_decoder.sv
// tb/tb_error_response_decoder.sv - scoreboard bench for error_response_decoder

module tb_error_response_decoder;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        Enable = 1'b0;
  logic        Error_Invalid_Request;
  logic        Error_Unsupported_Protocol;
  logic        Error_Busy;
  logic        Error_Unspecified;
  logic [7:0]  Error_Param2;
  logic        Not_Error_MSG;
  logic        Bad_MSG;
  logic [31:0] header;
  logic        Decode_done;
  logic        busy;

  error_response_decoder_if rx();

  error_response_decoder #(
    .MAX_MSG_BYTES     (8),
    .RX_TIMEOUT_CYCLES (16)
  ) dut (
    .clk                        (clk),
    .reset_L                    (reset_L),
    .Enable                     (Enable),
    .rx                         (rx),
    .Error_Invalid_Request      (Error_Invalid_Request),
    .Error_Unsupported_Protocol (Error_Unsupported_Protocol),
    .Error_Busy                 (Error_Busy),
    .Error_Unspecified          (Error_Unspecified),
    .Error_Param2               (Error_Param2),
    .Not_Error_MSG              (Not_Error_MSG),
    .Bad_MSG                    (Bad_MSG),
    .header                     (header),
    .Decode_done                (Decode_done),
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // res = {unspecified, busy, unsupported, invalid, param2[7:0], not_error, bad}
  typedef struct {
    logic [13:0] res;
    logic [31:0] hdr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        d;
  logic [7:0]  msg[$];
  logic [13:0] last_res;
  int          checks = 0;
  int          errors = 0;

  wire [13:0] res_vec = {Error_Unspecified, Error_Busy, Error_Unsupported_Protocol,
                         Error_Invalid_Request, Error_Param2, Not_Error_MSG, Bad_MSG};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic som, input logic eom);
    rx.byte_valid = v;
    rx.byte_in    = b;
    rx.SOM        = som;
    rx.EOM        = eom;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Reference: judge the whole message from its byte list and length.
  function automatic exp_t model();
    exp_t       e;
    int         n;
    logic       bad;
    logic [3:0] fl;
    n     = msg.size();
    e.hdr = '0;
    e.res = '0;
    e.cyc = 0;
    for (int i = 0; i < 4 && i < n; i++) e.hdr[31-8*i -: 8] = msg[i];
    bad = (n < 4) || (msg[0] != 8'h01) || (n > 8) || (n > 4 && msg[1] == 8'h7F);
    if (bad) begin
      e.res = 14'b00_0000_0000_0001;
    end else if (msg[1] == 8'h7F) begin
      case (msg[2])
        8'h01:   fl = 4'b0001;
        8'h02:   fl = 4'b0010;
        8'h03:   fl = 4'b0100;
        default: fl = 4'b1000;
      endcase
      e.res = {fl, msg[3], 2'b00};
    end else begin
      e.res = 14'b00_0000_0000_0010;
    end
    return e;
  endfunction

  task automatic send_msg(input int gapmax);
    exp_t e;
    int   n;
    n = msg.size();
    e = model();
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle($urandom_range(0, gapmax));
      if (i == n - 1) begin
        e.cyc    = cyc + 1;
        last_res = e.res;
        sb.push_back(e);
      end
      drive(1'b1, msg[i], i == 0, i == n - 1);
      if (i == 0 && n > 1) chk("clear_at_som", 64'(res_vec), 64'd0);
    end
    idle(1);
  endtask

  always @(negedge clk) begin
    if (Decode_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Decode_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 64'(res_vec), 64'(mon_e.res));
        chk("header", 64'(header), 64'(mon_e.hdr));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rx.byte_valid = 1'b0;
    rx.byte_in    = 8'h00;
    rx.SOM        = 1'b0;
    rx.EOM        = 1'b0;
    reset_L = 1'b0;
    Enable  = 1'b1;
    idle(3);
    chk("reset_results", 64'(res_vec), 64'd0);
    chk("reset_header", 64'(header), 64'd0);
    chk("reset_busy_done", 64'({busy, Decode_done}), 64'd0);
    reset_L = 1'b1;
    idle(2);

    msg = {8'h01, 8'h7F, 8'h01, 8'h00};               send_msg(0);
    msg = {8'h01, 8'h7F, 8'h02, 8'h01};               send_msg(1);
    msg = {8'h01, 8'h7F, 8'h09, 8'h00};               send_msg(0);
    msg = {8'h02, 8'h7F, 8'h03, 8'h00};               send_msg(0);
    msg = {8'h01, 8'h7F, 8'h03};                      send_msg(0);
    msg = {8'h01, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB}; send_msg(2);
    msg = {8'h01, 8'h7F, 8'h03, 8'h00, 8'hAA};        send_msg(0);
    msg = {8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; send_msg(0);
    msg = {8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};        send_msg(0);
    msg = {8'h01};                                    send_msg(0);

    // SOM on the third byte abandons the message; that byte is dropped.
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    d.res = 14'b00_0000_0000_0001;
    d.hdr = 32'h017F_0000;
    d.cyc = cyc + 1;
    sb.push_back(d);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    idle(1);
    chk("abandon_busy", 64'(busy), 64'd0);
    msg = {8'h01, 8'h01, 8'h05, 8'h06};               send_msg(0);

    // Reset mid-header discards the message.
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    reset_L = 1'b0;
    idle(1);
    chk("midreset_outputs", 64'({res_vec, header, busy, Decode_done}), 64'd0);
    reset_L = 1'b1;
    idle(1);
    msg = {8'h01, 8'h7F, 8'h03, 8'h00};               send_msg(1);

    // Enable low holds results and aborts reception.
    msg = {8'h01, 8'h7F, 8'h02, 8'h05};               send_msg(0);
    Enable = 1'b0;
    idle(3);
    chk("enable_low_holds", 64'(res_vec), 64'(last_res));
    Enable = 1'b1;
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
    Enable = 1'b0;
    idle(1);
    chk("enable_low_idle", 64'(busy), 64'd0);
    Enable = 1'b1;
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b1);
    idle(2);
    chk("enable_abort_busy", 64'(busy), 64'd0);
    chk("enable_abort_results", 64'(res_vec), 64'd0);

    // Stall after the second byte.
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0);
`ifdef ERR_RX_TIMEOUT_EN
    d.res = 14'b00_0000_0000_0001;
    d.hdr = 32'h017F_0000;
    d.cyc = cyc + 16;
    sb.push_back(d);
    idle(17);
    chk("timeout_busy", 64'(busy), 64'd0);
`else
    idle(20);
    chk("stall_busy", 64'(busy), 64'd1);
    msg = {8'h01, 8'h7F, 8'h03, 8'h00};
    d = model();
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    d.cyc = cyc + 1;
    sb.push_back(d);
    drive(1'b1, 8'h00, 1'b0, 1'b1);
    idle(1);
`endif

    for (int k = 0; k < 40; k++) begin
      int n;
      n = $urandom_range(1, 10);
      msg = {};
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      if ($urandom_range(0, 7) != 0) msg[0] = 8'h01;
      if (n > 1 && $urandom_range(0, 9) < 6) msg[1] = 8'h7F;
      if (n > 2) msg[2] = 8'($urandom_range(0, 6));
      send_msg(2);
      if ($urandom_range(0, 3) == 0) drive(1'b1, 8'($urandom), 1'b0, 1'($urandom));
    end

    idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/error_response_decoder.md
Name: error_response_decoder

Overview:
Initiator-side receive path for authentication response messages. It takes the incoming byte stream from the link layer and assembles the 4-byte header {ProtocolVersion, MessageType, Param1, Param2}, first byte first. It validates the header and, for ERROR responses, decodes Param1/Param2 into one-hot error flags. These flags are the same error classes that the responder-side error message builder encodes. Non-error responses are flagged and passed to the other response handlers.

Parameters:
MAX_MSG_BYTES, 8, maximum accepted message length in bytes including header; longer messages are a length error.
RX_TIMEOUT_CYCLES, 1024, inter-byte timeout in clk cycles; used only when ERR_RX_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
reset_L  input  1  synchronous reset, active low
Enable  input  1  decoder enabled; when low, the FSM returns to IDLE and the input stream is ignored
byte_in  input  8  received byte
byte_valid  input  1  byte_in is valid this cycle
SOM  input  1  qualifies the first byte of a message (sampled only with byte_valid)
EOM  input  1  qualifies the last byte of a message (sampled only with byte_valid)
Error_Invalid_Request  output  1  decoded ERROR, Param1=0x01
Error_Unsupported_Protocol  output  1  decoded ERROR, Param1=0x02
Error_Busy  output  1  decoded ERROR, Param1=0x03
Error_Unspecified  output  1  decoded ERROR, Param1=0x04 or unknown code
Error_Param2  output  8  Param2 of the decoded ERROR
Not_Error_MSG  output  1  valid header, MessageType != `ERROR_RESP_CMD
Bad_MSG  output  1  version mismatch, length error, SOM violation or timeout
header  output  `SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES  captured header, byte 0 in the MSBs
Decode_done  output  1  one-cycle pulse; all result outputs are valid
busy  output  1  message reception in progress

Behaviour:
- Reset (reset_L=0 at a clk edge): FSM=IDLE, byte counter=0, all outputs 0. Reset mid-message discards the message with no Decode_done.
- States:
  - IDLE: on byte_valid&SOM, store byte 0, set count=1, go HDR. byte_valid without SOM is ignored.
  - HDR: each byte_valid stores the next byte.
    - EOM before the 4th byte: go DONE with Bad_MSG.
    - 4th byte with EOM: go DONE.
    - 4th byte without EOM: go TAIL.
  - TAIL: counts trailing bytes until EOM, then goes DONE.
    - Any trailing byte on an ERROR response sets Bad_MSG, because ERROR carries no payload.
    - A total count above MAX_MSG_BYTES sets Bad_MSG, and the block keeps consuming until EOM.
  - DONE: exactly one cycle; pulse Decode_done; return to IDLE.
- Byte-level rules:
  - SOM on a byte while in HDR or TAIL: the current message is abandoned with Bad_MSG and Decode_done. That byte is not consumed, and the next message must restart with SOM.
  - A byte with SOM and EOM both set is a 1-byte message: Bad_MSG.
- Decode is registered into the result outputs on the DONE cycle.
  - Version: byte0 != `PROTOCOL_VERSION sets Bad_MSG, and no error flag is set.
  - byte1 == `ERROR_RESP_CMD: map Param1 to exactly one flag, and drive Error_Param2 = byte3. Any Param1 outside 0x01–0x04 maps to Error_Unspecified.
  - Otherwise: Not_Error_MSG=1.
  - Flags are mutually exclusive; Bad_MSG suppresses all error flags and Not_Error_MSG.
- Latency: Decode_done is asserted the cycle after the EOM byte is sampled.
- Holding results:
  - Result outputs hold until the next SOM is accepted, then clear to 0 in that same cycle.
  - header holds its last captured value until then.
- busy is 1 in HDR and TAIL, and 0 otherwise.
- Enable low clears the FSM to IDLE but does not clear held results.

Optional Feature:
ERR_RX_TIMEOUT_EN
- Defined: a counter reloads on every accepted byte while in HDR or TAIL. If RX_TIMEOUT_CYCLES cycles elapse with no byte_valid, the block goes to DONE with Bad_MSG=1, header is unchanged, and the block returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely for EOM.

Decomposition:
- Shared defines (existing header): `PROTOCOL_VERSION, `ERROR_RESP_CMD, `SIZE_OF_HEADER_VARS, `SIZE_OF_HEADER_IN_BYTES.
- New shared defines: error codes (`ERR_CODE_INVALID_REQ=8'h01, `ERR_CODE_UNSUP_PROT=8'h02, `ERR_CODE_BUSY=8'h03, `ERR_CODE_UNSPEC=8'h04) and the FSM state encodings.
- One natural sub-module: error_code_map, a combinational Param1 -> 4-bit one-hot flag mapping that can be reused by the builder side.

Test Plan:
- Bytes 01,7F,01,00 (EOM on last) -> Decode_done one cycle later; Error_Invalid_Request=1, Error_Param2=00, header=0x017F0100.
- Bytes 01,7F,02,01 -> Error_Unsupported_Protocol=1, Error_Param2=01. Then 01,7F,09,00 -> Error_Unspecified=1, and the previous flags are cleared at SOM.
- Bytes 02,7F,03,00 -> Bad_MSG=1, all error flags 0. Bytes 01,7F,03 with EOM on the 3rd -> Bad_MSG=1.
- Bytes 01,01,00,00,AA,BB (EOM on BB) -> Not_Error_MSG=1, Bad_MSG=0. Bytes 01,7F,03,00,AA -> Bad_MSG=1. A 9-byte message -> Bad_MSG=1.
- SOM reasserted on the 3rd byte -> abandoned message gives Bad_MSG plus Decode_done. Separately, reset_L=0 mid-header -> no Decode_done, outputs 0, and the next clean message decodes correctly.
- With ERR_RX_TIMEOUT_EN and RX_TIMEOUT_CYCLES=16: stall 16 cycles after byte 2 -> Bad_MSG=1, Decode_done, busy=0. Without the macro, the same stall -> busy stays 1.
